// File: rtl/cdb_writeback_buffer.sv
// Writeback buffer between a functional unit and the CDB: in-order FIFO with registered FU backpressure.
// Optional macro CDB_WB_BYPASS_EN forwards a result straight to the CDB when the FIFO is empty.
module cdb_writeback_buffer #(
    parameter int XLEN          = 32,
    parameter int ROB_SIZE      = 256,
    parameter int PHYS_REG_SIZE = 256,
    parameter int DEPTH         = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [XLEN-1:0]                  result_in,
    input  logic [$clog2(ROB_SIZE)-1:0]      rob_entry_in,
    input  logic [$clog2(PHYS_REG_SIZE)-1:0] dest_reg_in,
    input  logic                             flush,
    input  logic                             cdb_grant,
    output logic                             cdb_valid,
    output logic [XLEN-1:0]                  cdb_result,
    output logic [$clog2(ROB_SIZE)-1:0]      cdb_rob_entry,
    output logic [$clog2(PHYS_REG_SIZE)-1:0] cdb_dest_reg,
    output logic                             fu_stall,
    output logic                             overflow
);
    localparam int RW = $clog2(ROB_SIZE);
    localparam int DW = $clog2(PHYS_REG_SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    logic [XLEN-1:0] res_mem  [DEPTH];
    logic [RW-1:0]   rob_mem  [DEPTH];
    logic [DW-1:0]   dest_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fu_stall_q, fu_stall_d;
    logic          overflow_q, overflow_d;

    logic fifo_nonempty;
    logic pop_fifo;
    logic bypass_take;
    logic push;
    logic drop;

    assign fifo_nonempty = (count_q != '0);
    assign pop_fifo      = fifo_nonempty & cdb_grant;

`ifdef CDB_WB_BYPASS_EN
    logic bypass_active;
    // An empty FIFO lets the FU result ride the CDB in the same cycle; it is stored only if not granted.
    assign bypass_active = valid_in & ~fifo_nonempty;
    assign bypass_take   = bypass_active & cdb_grant;
    assign cdb_valid     = fifo_nonempty | bypass_active;
    assign cdb_result    = bypass_active ? result_in    : res_mem[rd_ptr_q];
    assign cdb_rob_entry = bypass_active ? rob_entry_in : rob_mem[rd_ptr_q];
    assign cdb_dest_reg  = bypass_active ? dest_reg_in  : dest_mem[rd_ptr_q];
`else
    assign bypass_take   = 1'b0;
    assign cdb_valid     = fifo_nonempty;
    assign cdb_result    = res_mem[rd_ptr_q];
    assign cdb_rob_entry = rob_mem[rd_ptr_q];
    assign cdb_dest_reg  = dest_mem[rd_ptr_q];
`endif

    assign push = valid_in & ~flush & ~bypass_take & ((count_q != FULL_CNT) | pop_fifo);
    assign drop = valid_in & ~flush & (count_q == FULL_CNT) & ~pop_fifo;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({push, pop_fifo})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // One spare slot absorbs the result already in flight when the FU sees the stall.
        fu_stall_d = ~flush & (count_d >= STALL_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fu_stall_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fu_stall_q <= fu_stall_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr_q]  <= result_in;
            rob_mem[wr_ptr_q]  <= rob_entry_in;
            dest_mem[wr_ptr_q] <= dest_reg_in;
        end
    end

    assign fu_stall = fu_stall_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cdb_writeback_buffer.sv
// Directed self-checking bench for cdb_writeback_buffer in its default (non-bypass) build.
module tb_cdb_writeback_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] result_in;
    logic [7:0]  rob_entry_in;
    logic [7:0]  dest_reg_in;
    logic        flush;
    logic        cdb_grant;
    logic        cdb_valid;
    logic [31:0] cdb_result;
    logic [7:0]  cdb_rob_entry;
    logic [7:0]  cdb_dest_reg;
    logic        fu_stall;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_writeback_buffer #(
        .XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .result_in(result_in),
        .rob_entry_in(rob_entry_in), .dest_reg_in(dest_reg_in), .flush(flush),
        .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_rob_entry(cdb_rob_entry), .cdb_dest_reg(cdb_dest_reg),
        .fu_stall(fu_stall), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] rob, input logic [7:0] dst);
        valid_in     = v;
        result_in    = res;
        rob_entry_in = rob;
        dest_reg_in  = dst;
    endtask

    logic [31:0] exp_heads [3];
    logic [47:0] model_q [$];

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        cdb_grant = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        #2;
        check_val("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check_val("rst_fu_stall", 64'(fu_stall), 64'(0));
        check_val("rst_overflow", 64'(overflow), 64'(0));
        #10 rst = 1'b1;

        // single result with grant: visible one cycle after the push, for exactly one cycle
        drive(1'b1, 32'h0000_0005, 8'h12, 8'h34);
        cdb_grant = 1'b1;
        tick();
        check_val("single_vld", 64'(cdb_valid), 64'(1));
        check_val("single_res", 64'(cdb_result), 64'h5);
        check_val("single_rob", 64'(cdb_rob_entry), 64'h12);
        check_val("single_dst", 64'(cdb_dest_reg), 64'h34);
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        tick();
        check_val("single_gone", 64'(cdb_valid), 64'(0));

        // fill A..D without grant, stall rises after the third push
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 8'(8'h01 + i), 8'(8'h11 + i));
            tick();
            check_val($sformatf("fill_stall%0d", i), 64'(fu_stall), 64'(i >= 2));
        end
        check_val("fill_vld", 64'(cdb_valid), 64'(1));
        check_val("fill_headA", 64'(cdb_result), 64'hA0);
        check_val("fill_ovf0", 64'(overflow), 64'(0));
        drive(1'b1, 32'hE0, 8'h0E, 8'h1E);
        tick();
        check_val("drop_ovf", 64'(overflow), 64'(1));
        check_val("drop_headA", 64'(cdb_result), 64'hA0);
        check_val("drop_stall", 64'(fu_stall), 64'(1));

        // full buffer: push F while A is granted
        drive(1'b1, 32'hF0, 8'h0F, 8'h1F);
        cdb_grant = 1'b1;
        tick();
        check_val("full_pp_headB", 64'(cdb_result), 64'hA1);
        check_val("full_pp_ovf", 64'(overflow), 64'(1));
        check_val("full_pp_stall", 64'(fu_stall), 64'(1));
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        exp_heads[0] = 32'hA2;
        exp_heads[1] = 32'hA3;
        exp_heads[2] = 32'hF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("drain_head%0d", i), 64'(cdb_result), 64'(exp_heads[i]));
        end
        check_val("drain_F_rob", 64'(cdb_rob_entry), 64'h0F);
        check_val("drain_F_dst", 64'(cdb_dest_reg), 64'h1F);
        tick();
        check_val("drain_empty", 64'(cdb_valid), 64'(0));
        check_val("drain_stall", 64'(fu_stall), 64'(0));

        // flush with three entries and a simultaneous push
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 8'(8'h20 + i), 8'(8'h30 + i));
            tick();
        end
        check_val("pre_flush_stall", 64'(fu_stall), 64'(1));
        drive(1'b1, 32'hCC, 8'h2C, 8'h3C);
        flush = 1'b1;
        tick();
        check_val("flush_vld", 64'(cdb_valid), 64'(0));
        check_val("flush_stall", 64'(fu_stall), 64'(0));
        check_val("flush_ovf_kept", 64'(overflow), 64'(1));
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        tick();
        check_val("flush_no_push", 64'(cdb_valid), 64'(0));

        // asynchronous reset mid-cycle with two entries held
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hD0 + 32'(i), 8'(8'h50 + i), 8'(8'h60 + i));
            tick();
        end
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        check_val("pre_rst_vld", 64'(cdb_valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_vld", 64'(cdb_valid), 64'(0));
        check_val("mid_rst_stall", 64'(fu_stall), 64'(0));
        check_val("mid_rst_ovf", 64'(overflow), 64'(0));
        #3 rst = 1'b1;
        drive(1'b1, 32'h77, 8'h55, 8'h66);
        tick();
        check_val("post_rst_vld", 64'(cdb_valid), 64'(1));
        check_val("post_rst_res", 64'(cdb_result), 64'h77);
        check_val("post_rst_rob", 64'(cdb_rob_entry), 64'h55);
        check_val("post_rst_dst", 64'(cdb_dest_reg), 64'h66);
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        cdb_grant = 1'b1;
        tick();
        check_val("post_rst_pop", 64'(cdb_valid), 64'(0));

        // continuous stream of 10 results against alternating grant, FU honours fu_stall
        begin
            int sent = 0;
            int cyc  = 0;
            while ((sent < 10 || model_q.size() != 0) && cyc < 100) begin
                logic v;
                logic g;
                int   sz;
                v = (sent < 10) && !fu_stall;
                g = (cyc % 2 == 1);
                drive(v, 32'(32'h1000 + sent), 8'(8'h40 + sent), 8'(8'h80 + sent));
                cdb_grant = g;
                sz = model_q.size();
                if (sz > 0 && g) void'(model_q.pop_front());
                if (v && (sz < 4 || (sz > 0 && g))) model_q.push_back({result_in, rob_entry_in, dest_reg_in});
                if (v) sent++;
                tick();
                cyc++;
                check_val("wrap_vld", 64'(cdb_valid), 64'(model_q.size() != 0));
                if (model_q.size() != 0)
                    check_val("wrap_head", 64'({cdb_result, cdb_rob_entry, cdb_dest_reg}), 64'(model_q[0]));
            end
            check_val("wrap_done", 64'(cyc < 100), 64'(1));
        end
        drive(1'b0, 32'h0, 8'h0, 8'h0);
        cdb_grant = 1'b0;
        check_val("wrap_no_ovf", 64'(overflow), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_writeback_buffer.md
CDB_WRITEBACK_BUFFER -- requirements
Module: cdb_writeback_buffer

Interface
REQ-001 Parameter XLEN, 32, data width of a functional-unit result.
REQ-002 Parameter ROB_SIZE, 256, number of ROB entries; rob tag width is $clog2(ROB_SIZE).
REQ-003 Parameter PHYS_REG_SIZE, 256, number of physical registers; dest tag width is $clog2(PHYS_REG_SIZE).
REQ-004 Parameter DEPTH, 4, number of FIFO entries; power of two, minimum 2.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 valid_in  input  1  FU result valid this cycle.
REQ-008 result_in  input  XLEN  FU result data.
REQ-009 rob_entry_in  input  $clog2(ROB_SIZE)  ROB tag of the result.
REQ-010 dest_reg_in  input  $clog2(PHYS_REG_SIZE)  physical destination tag.
REQ-011 flush  input  1  pipeline flush; discards all buffered results.
REQ-012 cdb_grant  input  1  CDB arbiter accepts the head entry this cycle.
REQ-013 cdb_valid  output  1  head entry valid and requesting the CDB.
REQ-014 cdb_result  output  XLEN  head entry data.
REQ-015 cdb_rob_entry  output  $clog2(ROB_SIZE)  head entry ROB tag.
REQ-016 cdb_dest_reg  output  $clog2(PHYS_REG_SIZE)  head entry destination tag.
REQ-017 fu_stall  output  1  registered backpressure to FU issue.
REQ-018 overflow  output  1  sticky error flag: a result was dropped.

Function
REQ-019 The block SHALL be a DEPTH-entry circular FIFO with read pointer, write pointer and count of width $clog2(DEPTH+1).
REQ-020 Push SHALL occur when valid_in=1 and (count<DEPTH or pop occurs in the same cycle).
REQ-021 Pop SHALL occur when cdb_valid=1 and cdb_grant=1; cdb_grant while cdb_valid=0 SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH and when count=0.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-024 cdb_valid SHALL equal (count!=0); cdb_* data SHALL reflect the entry at the read pointer, held stable until popped.
REQ-025 Latency without bypass SHALL be 1 cycle: a push at edge N is visible on cdb_* after edge N.
REQ-026 fu_stall SHALL be registered and asserted when next-state count >= DEPTH-1, covering the one-cycle FU pipeline slack.
REQ-027 valid_in=1 with count=DEPTH and no pop SHALL drop the input and set overflow; overflow SHALL clear only on reset.
REQ-028 flush SHALL, at the next edge, zero count and both pointers, deassert fu_stall, and discard any same-cycle push; overflow SHALL be unaffected.
REQ-029 Results SHALL leave in arrival order; data SHALL pass unmodified.

Reset
REQ-030 rst=0 SHALL immediately force count=0, pointers=0, cdb_valid=0, fu_stall=0, overflow=0; payload storage need not reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after rst returns to 1 SHALL be accepted normally.

Configuration
REQ-032 Macro CDB_WB_BYPASS_EN: when defined, valid_in=1 with count=0 SHALL drive cdb_valid and cdb_* combinationally from the inputs in the same cycle; with cdb_grant=1 the result SHALL NOT be stored, and with cdb_grant=0 it SHALL be pushed normally.
REQ-033 Without CDB_WB_BYPASS_EN, all cdb_* outputs SHALL come from FIFO storage only (REQ-025 latency).

Verification
REQ-034 Single push of result 0x0000_0005, rob 0x12, dest 0x34, cdb_grant=1 -> cdb_valid for exactly 1 cycle, one cycle later (same cycle with bypass), fields exact.
REQ-035 Push 4 results A..D with cdb_grant=0 -> fu_stall=1 after the 3rd push; count=4; a 5th push drops E, overflow=1; granting then yields A,B,C,D in order.
REQ-036 Full buffer, push F with cdb_grant=1 the same cycle -> A popped, F accepted, count stays 4, overflow unchanged.
REQ-037 Fill 3 entries, assert flush together with valid_in=1 -> next cycle cdb_valid=0, fu_stall=0, count=0.
REQ-038 Push/pop 10 results continuously with alternating grant -> pointers wrap twice, order preserved, no loss.
REQ-039 Assert rst=0 mid-cycle with 2 entries held -> outputs zeroed before the next clock edge; after release, a new push is delivered correctly.
